// File: rtl/present_dec80_if.sv
// Request/response bundle for the PRESENT-80 decryption core: start/key/ct in, busy/done/pt out.
interface present_dec80_if;
  logic        start;
  logic [79:0] key;
  logic [63:0] ct;
  logic        busy;
  logic        done;
  logic [63:0] pt;

  modport master (output start, key, ct, input busy, done, pt);
  modport slave  (input start, key, ct, output busy, done, pt);
endinterface

// File: rtl/present_dec80.sv
// Iterative PRESENT-80 decryption: 31 forward key-schedule steps to reach K32, then 31
// inverse rounds that walk the key schedule back down to K1, one step per clock.
module present_dec80 (
  input  logic           clk,
  input  logic           rst,
  present_dec80_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StKeyExp, StRound, StFinal} state_e;

  state_e      r_state;
  logic [4:0]  r_cnt;
  logic [63:0] r_data;
  logic [79:0] r_key;
  logic        r_busy;
  logic        r_done;
  logic [63:0] r_pt;

  logic [63:0] w_add;
  logic [63:0] w_perm;
  logic [63:0] w_sub;
  logic [79:0] w_key_fwd;
  logic [79:0] w_key_inv;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    case (x)
      4'h0: sbox_inv = 4'h5;  4'h1: sbox_inv = 4'hE;  4'h2: sbox_inv = 4'hF;  4'h3: sbox_inv = 4'h8;
      4'h4: sbox_inv = 4'hC;  4'h5: sbox_inv = 4'h1;  4'h6: sbox_inv = 4'h2;  4'h7: sbox_inv = 4'hD;
      4'h8: sbox_inv = 4'hB;  4'h9: sbox_inv = 4'h4;  4'hA: sbox_inv = 4'h6;  4'hB: sbox_inv = 4'h3;
      4'hC: sbox_inv = 4'h0;  4'hD: sbox_inv = 4'h7;  4'hE: sbox_inv = 4'h9;  default: sbox_inv = 4'hA;
    endcase
  endfunction

  // Also serves FINAL: data ^ K1 is the plaintext.
  assign w_add = r_data ^ r_key[79:16];

  for (genvar i = 0; i < 63; i++) begin : g_pinv
    localparam int unsigned Src = (16 * i) % 63;
    assign w_perm[i] = w_add[Src];
  end
  assign w_perm[63] = w_add[63];

  for (genvar n = 0; n < 16; n++) begin : g_sinv
    assign w_sub[4*n +: 4] = sbox_inv(w_perm[4*n +: 4]);
  end

  always_comb begin
    w_key_fwd          = {r_key[18:0], r_key[79:19]};
    w_key_fwd[79:76]   = sbox(w_key_fwd[79:76]);
    w_key_fwd[19:15]   = w_key_fwd[19:15] ^ r_cnt;
  end

  logic [79:0] w_key_tmp;
  always_comb begin
    w_key_tmp          = r_key;
    w_key_tmp[19:15]   = w_key_tmp[19:15] ^ r_cnt;
    w_key_tmp[79:76]   = sbox_inv(w_key_tmp[79:76]);
    w_key_inv          = {w_key_tmp[60:0], w_key_tmp[79:61]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= 5'd0;
      r_data  <= 64'd0;
      r_key   <= 80'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pt    <= 64'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_data  <= bus.ct;
            r_key   <= bus.key;
            r_cnt   <= 5'd1;
            r_busy  <= 1'b1;
            r_state <= StKeyExp;
          end
        end
        StKeyExp: begin
          r_key <= w_key_fwd;
          if (r_cnt == 5'd31) begin
            r_cnt   <= 5'd31;
            r_state <= StRound;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        StRound: begin
          r_data <= w_sub;
          r_key  <= w_key_inv;
          r_cnt  <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) r_state <= StFinal;
        end
        StFinal: begin
          r_pt    <= w_add;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.pt   = r_pt;

endmodule
